fpu_divide: RTL

//  Iterative IEEE-754 single-precision divider: quotient = a / b.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_div_step.sv | 19 +
 rtl/fpu_divide.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the iterative single-precision divider.
// FPU_DIV_RADIX4_EN selects two restoring steps per cycle instead of one.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } fpu_div_state_t;

    localparam int          FP_BIAS     = 127;
    localparam logic [7:0]  FP_EXP_INF  = 8'hff;
    localparam logic [31:0] FP_ONE_MANT = 32'h4000_0000;
    localparam int          QBITS       = 31;

`ifdef FPU_DIV_RADIX4_EN
    localparam int DIV_STEPS  = 2;
    localparam int DIV_CYCLES = 16;
`else
    localparam int DIV_STEPS  = 1;
    localparam int DIV_CYCLES = 31;
`endif

    // Quotient bits generated in total; radix-4 makes one more than QBITS.
    localparam int QGEN_W = DIV_STEPS * DIV_CYCLES;

    function automatic logic [9:0] div_exp(input logic [7:0] ea, input logic [7:0] eb);
        return {2'b00, ea} - {2'b00, eb} + 10'(FP_BIAS);
    endfunction

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// The remainder entering a step is always below twice the divisor.
module fpu_div_step (
    input  logic [24:0] rem_i,
    input  logic [23:0] divisor_i,
    output logic [24:0] rem_o,
    output logic        q_o
);

    logic [23:0] diff;
    logic [23:0] sel;

    // When the subtract is taken the true difference is below 2^24, so 24 bits suffice.
    assign diff  = rem_i[23:0] - divisor_i;
    assign q_o   = (rem_i >= {1'b0, divisor_i});
    assign sel   = q_o ? diff : rem_i[23:0];
    assign rem_o = {sel, 1'b0};

endmodule

// File: rtl/fpu_divide.sv
// Iterative IEEE single divider producing an unrounded quotient for normalize/pack.
// FPU_DIV_RADIX4_EN: two chained restoring steps per DIVIDE cycle (16 cycles instead of 31).
//   state  | meaning
//   IDLE   | waiting for start; busy low
//   DIVIDE | one (or two) quotient bits per cycle
//   DONE   | result held on div_* until div_ack
module fpu_divide
    import fpu_pkg::*;
(
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  dest_in_i,
    input  logic        div_ack_i,
    output logic        busy_o,
    output logic        div_valid_o,
    output logic [31:0] div_mantissa_o,
    output logic [7:0]  div_exponent_o,
    output logic        div_sign_o,
    output logic [4:0]  div_dest_o
);

    localparam logic [4:0] CNT_INIT = 5'(DIV_CYCLES - 1);
    localparam int         QKEEP_W  = QGEN_W - DIV_STEPS;

    fpu_div_state_t     state_q;
    logic               busy_q;
    logic [4:0]         cnt_q;
    logic [24:0]        rem_q;
    logic [23:0]        divisor_q;
    logic [QKEEP_W-1:0] quo_q;
    logic [9:0]         e_q;
    logic [31:0]        mant_q;
    logic [7:0]         expo_q;
    logic               sign_q;
    logic [4:0]         dest_q;

    logic [24:0]        rem_d;
    logic [QGEN_W-1:0]  quo_d;
    logic [31:0]        mant_d;
    logic               e_ovf, e_udf;
    logic               a_zero, a_inf, b_zero, b_inf;
    logic               special_inf, special_zero;

    assign a_zero       = (a_i[30:23] == 8'h00);
    assign a_inf        = (a_i[30:23] == FP_EXP_INF);
    assign b_zero       = (b_i[30:23] == 8'h00);
    assign b_inf        = (b_i[30:23] == FP_EXP_INF);
    assign special_inf  = b_zero | a_inf;
    assign special_zero = a_zero | b_inf;

    logic [24:0] rem_s0;
    logic        q_s0;

    fpu_div_step u_step0 (
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_s0),
        .q_o       (q_s0)
    );

`ifdef FPU_DIV_RADIX4_EN
    logic q_s1;

    fpu_div_step u_step1 (
        .rem_i     (rem_s0),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .q_o       (q_s1)
    );

    assign quo_d  = {quo_q, q_s0, q_s1};
    // The 32nd bit lies below the sticky position and is folded into it.
    assign mant_d = {1'b0, quo_d[31:2], quo_d[1] | quo_d[0] | (rem_d != '0)};
`else
    assign rem_d  = rem_s0;
    assign quo_d  = {quo_q, q_s0};
    assign mant_d = {1'b0, quo_d[30:1], quo_d[0] | (rem_d != '0)};
`endif

    assign e_ovf = ~e_q[9] & (e_q[8] | (&e_q[7:0]));
    assign e_udf = e_q[9] | (e_q == '0);

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            e_q       <= '0;
            mant_q    <= '0;
            expo_q    <= '0;
            sign_q    <= 1'b0;
            dest_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        sign_q <= a_i[31] ^ b_i[31];
                        dest_q <= dest_in_i;
                        if (special_inf) begin
                            state_q <= DONE;
                            expo_q  <= FP_EXP_INF;
                            mant_q  <= FP_ONE_MANT;
                        end else if (special_zero) begin
                            state_q <= DONE;
                            expo_q  <= '0;
                            mant_q  <= '0;
                        end else begin
                            state_q   <= DIVIDE;
                            rem_q     <= {2'b01, a_i[22:0]};
                            divisor_q <= {1'b1, b_i[22:0]};
                            quo_q     <= '0;
                            cnt_q     <= CNT_INIT;
                            e_q       <= div_exp(a_i[30:23], b_i[30:23]);
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d[QKEEP_W-1:0];
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (e_ovf) begin
                            expo_q <= FP_EXP_INF;
                            mant_q <= FP_ONE_MANT;
                        end else if (e_udf) begin
                            expo_q <= '0;
                            mant_q <= '0;
                        end else begin
                            expo_q <= e_q[7:0];
                            mant_q <= mant_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    if (div_ack_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid drops in the ack cycle itself so normalize never takes a result twice.
    assign div_valid_o    = (state_q == DONE) & ~div_ack_i;
    assign busy_o         = busy_q;
    assign div_mantissa_o = mant_q;
    assign div_exponent_o = expo_q;
    assign div_sign_o     = sign_q;
    assign div_dest_o     = dest_q;

endmodule
